garage_door_plant: RTL and testbench

- Cycle-accurate behavioural plant for the automatic garage door controller. It is the other end of the controller's interface.
- Consumes the controller's motor commands (UP_M, DN_M) and produces the signals the controller consumes:
  - limit switches UP_Max and DN_Max, derived from a modelled door position;
  - a debounced single-cycle Activate pulse, derived from a raw push-button.
- It closes the loop around the controller in system-level benches. It is synthesizable, so it can also drive the controller on an FPGA demo board.

---
 rtl/garage_door_plant.sv | 124 ++++++++++++
 tb/tb_garage_door_plant.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/garage_door_plant.sv
// Behavioural garage-door plant: turns motor commands into a stepped door position with
// limit switches, and a bouncy push-button into a single debounced Activate pulse.
module garage_door_plant #(
    parameter int TRAVEL   = 16,
    parameter int STEP_DIV = 4,
    parameter int DEB_CYC  = 3,
    parameter int PW       = 5
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          UP_M,
    input  logic          DN_M,
    input  logic          Btn_Raw,
    input  logic          Obstruct,
    output logic          UP_Max,
    output logic          DN_Max,
    output logic          Activate,
    output logic [PW-1:0] Pos,
    output logic          Fault
);

    localparam int SW = $clog2(STEP_DIV + 1);
    localparam int DW = $clog2(DEB_CYC + 1);
    localparam logic [PW-1:0] POS_MAX  = PW'(TRAVEL);
    localparam logic [SW-1:0] STEP_LIM = SW'(STEP_DIV);
    localparam logic [DW-1:0] DEB_LIM  = DW'(DEB_CYC);

    typedef enum logic [1:0] {S_IDLE, S_RISE, S_FALL, S_FAULT} state_t;

    state_t          r_state;
    logic [SW-1:0]   r_presc;
    logic            r_s1;
    logic            r_s2;
    logic            r_level;
    logic [DW-1:0]   r_deb_cnt;

    state_t          w_state_next;
    logic [SW-1:0]   w_presc_base;
    logic [SW-1:0]   w_presc_inc;
    logic [SW-1:0]   w_presc_next;
    logic [PW-1:0]   w_pos_next;
    logic            w_at_limit;
    logic            w_moving;
    logic [DW-1:0]   w_deb_inc;

    always_comb begin
        w_state_next = S_IDLE;
        case ({UP_M, DN_M})
            2'b10:   w_state_next = S_RISE;
            2'b01:   w_state_next = S_FALL;
            2'b11:   w_state_next = S_FAULT;
            default: w_state_next = S_IDLE;
        endcase

        // Any change of commanded state restarts the count, so the first edge in a new direction counts as 1.
        w_presc_base = (w_state_next == r_state) ? r_presc : '0;
        w_presc_inc  = w_presc_base + SW'(1);
        w_moving     = (w_state_next == S_RISE) || (w_state_next == S_FALL);
        w_at_limit   = ((w_state_next == S_RISE) && (Pos == POS_MAX)) ||
                       ((w_state_next == S_FALL) && (Pos == '0));

        w_presc_next = '0;
        w_pos_next   = Pos;
        if (w_moving) begin
            if (w_at_limit) begin
                w_presc_next = '0;
            end else if (Obstruct) begin
                w_presc_next = w_presc_base;
            end else if (w_presc_inc == STEP_LIM) begin
                w_presc_next = '0;
                w_pos_next   = (w_state_next == S_RISE) ? Pos + PW'(1) : Pos - PW'(1);
            end else begin
                w_presc_next = w_presc_inc;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            Pos     <= '0;
            UP_Max  <= 1'b0;
            DN_Max  <= 1'b1;
            Fault   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_presc <= w_presc_next;
            Pos     <= w_pos_next;
            UP_Max  <= (w_pos_next == POS_MAX);
            DN_Max  <= (w_pos_next == '0);
            if (w_state_next == S_FAULT) begin
                Fault <= 1'b1;
            end
        end
    end

    assign w_deb_inc = r_deb_cnt + DW'(1);

    // Debounce works on the synchronised level; a level change is accepted only after DEB_CYC stable edges.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_level   <= 1'b0;
            r_deb_cnt <= '0;
            Activate  <= 1'b0;
        end else begin
            r_s1     <= Btn_Raw;
            r_s2     <= r_s1;
            Activate <= 1'b0;
            if (r_s2 == r_level) begin
                r_deb_cnt <= '0;
            end else if (w_deb_inc == DEB_LIM) begin
                r_level   <= r_s2;
                r_deb_cnt <= '0;
                Activate  <= r_s2;
            end else begin
                r_deb_cnt <= w_deb_inc;
            end
        end
    end

endmodule

// File: tb/tb_garage_door_plant.sv
// Directed bench for garage_door_plant: a per-edge vector table for reverse/obstruct timing,
// plus hand sequences for reset, full travel, debounce, fault and asynchronous reset.
module tb_garage_door_plant;

    logic       CLK;
    logic       RST;
    logic       UP_M;
    logic       DN_M;
    logic       Btn_Raw;
    logic       Obstruct;
    logic       UP_Max;
    logic       DN_Max;
    logic       Activate;
    logic [4:0] Pos;
    logic       Fault;

    garage_door_plant #(.TRAVEL(16), .STEP_DIV(4), .DEB_CYC(3), .PW(5)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .UP_M     (UP_M),
        .DN_M     (DN_M),
        .Btn_Raw  (Btn_Raw),
        .Obstruct (Obstruct),
        .UP_Max   (UP_Max),
        .DN_Max   (DN_Max),
        .Activate (Activate),
        .Pos      (Pos),
        .Fault    (Fault)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic       up;
        logic       dn;
        logic       btn;
        logic       obs;
        logic [4:0] pos;
        logic       upm;
        logic       dnm;
        logic       act;
        logic       flt;
    } vec_t;

    vec_t vecs[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    // Outputs packed as {Pos, UP_Max, DN_Max, Activate, Fault}.
    function automatic logic [8:0] pack(input logic [4:0] p, input logic u, input logic d,
                                        input logic a, input logic f);
        return {p, u, d, a, f};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    endtask

    task automatic chk_outs(input string name, input logic [4:0] p, input logic u, input logic d,
                            input logic a, input logic f);
        chk(name, 32'(pack(Pos, UP_Max, DN_Max, Activate, Fault)), 32'(pack(p, u, d, a, f)));
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic set_in(input logic u, input logic d, input logic b, input logic o);
        UP_M = u; DN_M = d; Btn_Raw = b; Obstruct = o;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0);
        RST = 1'b0;
        #2;
        RST = 1'b1;
    endtask

    task automatic add(input int n, input logic u, input logic d, input logic b, input logic o,
                       input logic [4:0] p, input logic um, input logic dm, input logic a,
                       input logic f);
        vec_t v;
        v.up = u; v.dn = d; v.btn = b; v.obs = o;
        v.pos = p; v.upm = um; v.dnm = dm; v.act = a; v.flt = f;
        repeat (n) vecs.push_back(v);
    endtask

    initial begin
        // Reverse and obstruct timing, one record per clock edge starting from reset.
        add(3, 1, 0, 0, 0, 5'd0, 0, 1, 0, 0);
        add(3, 1, 0, 0, 0, 5'd1, 0, 0, 0, 0);
        add(3, 0, 1, 0, 0, 5'd1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 5'd0, 0, 1, 0, 0);
        add(2, 1, 0, 0, 0, 5'd0, 0, 1, 0, 0);
        add(8, 1, 0, 0, 1, 5'd0, 0, 1, 0, 0);
        add(1, 1, 0, 0, 0, 5'd0, 0, 1, 0, 0);
        add(1, 1, 0, 0, 0, 5'd1, 0, 0, 0, 0);

        RST = 1'b0;
        set_in(0, 0, 0, 0);
        @(negedge CLK);

        for (int k = 0; k < 6; k++) begin
            set_in(k[0], k[1], ~k[0], 0);
            tick();
            chk_outs("reset_hold", 5'd0, 0, 1, 0, 0);
        end
        set_in(0, 0, 0, 0);
        RST = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk_outs("idle_after_reset", 5'd0, 0, 1, 0, 0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i].up, vecs[i].dn, vecs[i].btn, vecs[i].obs);
            tick();
            chk_outs($sformatf("vec%0d", i), vecs[i].pos, vecs[i].upm, vecs[i].dnm,
                     vecs[i].act, vecs[i].flt);
        end

        do_reset();
        @(negedge CLK);
        for (int k = 1; k <= 70; k++) begin
            int p;
            set_in(1, 0, 0, 0);
            tick();
            p = (k / 4 > 16) ? 16 : k / 4;
            chk_outs($sformatf("open_e%0d", k), 5'(p), p == 16, p == 0, 0, 0);
        end
        for (int k = 1; k <= 70; k++) begin
            int p;
            set_in(0, 1, 0, 0);
            tick();
            p = 16 - ((k / 4 > 16) ? 16 : k / 4);
            chk_outs($sformatf("close_e%0d", k), 5'(p), p == 16, p == 0, 0, 0);
        end

        set_in(0, 0, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            Btn_Raw = (k <= 2);
            tick();
            chk($sformatf("glitch_e%0d", k), 32'(Activate), 32'd0);
        end
        for (int k = 1; k <= 10; k++) begin
            Btn_Raw = 1'b1;
            tick();
            chk($sformatf("press_e%0d", k), 32'(Activate), 32'(k == 5));
        end
        for (int k = 1; k <= 10; k++) begin
            Btn_Raw = 1'b0;
            tick();
            chk($sformatf("release_e%0d", k), 32'(Activate), 32'd0);
        end

        do_reset();
        @(negedge CLK);
        set_in(1, 1, 0, 0);
        tick();
        chk_outs("fault_set", 5'd0, 0, 1, 0, 1);
        for (int k = 1; k <= 8; k++) begin
            set_in(1, 0, 0, 0);
            tick();
            chk_outs($sformatf("fault_move_e%0d", k), 5'(k / 4), 0, k < 4, 0, 1);
        end
        set_in(1, 1, 0, 0);
        tick();
        chk_outs("fault_hold_pos", 5'd2, 0, 0, 0, 1);
        set_in(0, 0, 0, 0);
        tick();
        chk_outs("fault_sticky", 5'd2, 0, 0, 0, 1);
        do_reset();
        #1;
        chk_outs("fault_cleared", 5'd0, 0, 1, 0, 0);

        @(negedge CLK);
        for (int k = 1; k <= 28; k++) begin
            set_in(1, 0, 0, 0);
            tick();
        end
        chk_outs("travel_to_7", 5'd7, 0, 0, 0, 0);
        RST = 1'b0;
        #1;
        chk_outs("async_reset", 5'd0, 0, 1, 0, 0);
        #1;
        RST = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk_outs($sformatf("restart_e%0d", k), 5'(k / 4), 0, k < 4, 0, 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
